key_debounce: RTL
=================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable cycles required to accept a level change (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter LONG_CYCLES, default 50000000, meaning hold cycles in PRESSED before the long-press pulse (1 s at 50 MHz).
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 1, meaning raw key inputs read 0 when pressed.
REQ-004 The block SHALL have port clk, input, 1 bit, system clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit, reset; one clock; reset is asynchronous and active-low.
REQ-006 The block SHALL have ports KEY0 and KEY1, input, 1 bit each, raw asynchronous push-button lines.
REQ-007 The block SHALL have ports key0_level and key1_level, output, 1 bit each, debounced pressed level, 1 = pressed.
REQ-008 The block SHALL have ports key0_press and key1_press, output, 1 bit each, one-cycle pulse on accepted press.
REQ-009 The block SHALL have ports key0_long and key1_long, output, 1 bit each, one-cycle long-press pulse (see Configuration).

Function
REQ-010 Each key SHALL pass a 2-FF synchronizer; polarity is applied after it, giving sample s (1 = pressed).
REQ-011 Each channel SHALL run an FSM with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT and a counter sized clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES))+1 bits.
REQ-012 IDLE, s=1: go to PRESS_WAIT, counter=1; otherwise stay.
REQ-013 PRESS_WAIT, s=0: go to IDLE, counter=0 (bounce discards progress); s=1 and counter==DEBOUNCE_CYCLES-1: go to PRESSED, counter=0; else counter+1.
REQ-014 The PRESSED and RELEASE_WAIT transitions SHALL mirror REQ-012/REQ-013 with s inverted; RELEASE_WAIT, s=1 returns to PRESSED.
REQ-015 level SHALL be registered and equal 1 exactly while the state is PRESSED or RELEASE_WAIT.
REQ-016 press SHALL be high for exactly the one cycle after the PRESS_WAIT->PRESSED transition edge, at the same time level first reads 1.
REQ-017 Total press latency SHALL be 2 synchronizer cycles + DEBOUNCE_CYCLES from a clean raw edge; release latency SHALL be identical.
REQ-018 The counter SHALL saturate; it never wraps.
REQ-019 The two channels SHALL be fully independent; simultaneous presses SHALL produce simultaneous pulses.
REQ-020 DEBOUNCE_CYCLES=1 SHALL be legal: acceptance occurs on the first sampled cycle of the new level.

Reset
REQ-021 rst_n low SHALL asynchronously clear synchronizer flops to the unpressed level, states to IDLE, counters to 0, and all outputs to 0.
REQ-022 A key held through reset release SHALL be debounced from scratch and produce exactly one press pulse.
REQ-023 Reset asserted mid-PRESS_WAIT or mid-PRESSED SHALL abort without emitting press or long.

Configuration
REQ-024 With macro KEY_DEBOUNCE_LONG_PRESS_EN defined, in PRESSED the counter SHALL count hold cycles and key*_long SHALL pulse once when it reaches LONG_CYCLES-1, with no repeat until the key is released and pressed again; entering RELEASE_WAIT SHALL freeze the hold count, and returning to PRESSED SHALL resume it.
REQ-025 With KEY_DEBOUNCE_LONG_PRESS_EN undefined, key*_long SHALL be tied 0 and no hold-count logic SHALL be synthesized.

Structure
REQ-026 The FSM state encoding typedef and the state constants SHALL live in shared package key_pkg.
REQ-027 The per-key synchronizer, FSM and counter SHALL be sub-module key_debounce_ch, instantiated twice.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1)
REQ-028 Bench: KEY0 falls and stays low -> key0_press pulses exactly once, 6 cycles after the edge; key0_level=1 from that cycle.
REQ-029 Bench: KEY0 toggles low/high every 2 cycles for 30 cycles, then stays high -> no press pulse; key0_level stays 0.
REQ-030 Bench: KEY0 low for 40 cycles with LONG_PRESS_EN defined -> one press pulse and one long pulse 20 cycles after press; undefined -> key0_long stays 0.
REQ-031 Bench: KEY0 and KEY1 fall on the same edge -> key0_press and key1_press pulse on the same cycle.
REQ-032 Bench: KEY1 low, rst_n pulsed low for 3 cycles in PRESS_WAIT, then released with KEY1 held -> outputs 0 during reset, then a single key1_press 6 cycles after rst_n rises.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the two-key debouncer: channel FSM state encoding
// and a small helper used to size the per-channel counter.
package key_pkg;

    // Per-channel debounce FSM states
    typedef enum logic [1:0] {
        KEY_IDLE         = 2'd0,
        KEY_PRESS_WAIT   = 2'd1,
        KEY_PRESSED      = 2'd2,
        KEY_RELEASE_WAIT = 2'd3
    } key_state_e;

    // Larger of two cycle counts, used to size the debounce counter
    function automatic int unsigned key_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-FF synchronizer, polarity fix-up, debounce FSM with
// a saturating counter, and registered level/press/long outputs.
// The long-press hold counter exists only when KEY_DEBOUNCE_LONG_PRESS_EN is defined.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic level_o,
    output logic press_o,
    output logic long_o
);

    localparam int unsigned CNT_W      = $clog2(key_max(DEBOUNCE_CYCLES, LONG_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // With a one-cycle debounce the first pressed sample is accepted straight from IDLE
    localparam bit               DEB_SINGLE = (DEBOUNCE_CYCLES <= 1);
    // Raw line level when the key is not pressed
    localparam logic             RAW_IDLE   = ACTIVE_LOW;

    logic [1:0]       sync_q;
    logic             sample;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             level_q, level_d;
    logic             press_q, press_d;

    // Two-flop synchronizer on the raw key line, reset to the unpressed level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{RAW_IDLE}};
        end else begin
            sync_q <= {sync_q[0], key_i};
        end
    end

    assign sample  = ACTIVE_LOW ? ~sync_q[1] : sync_q[1];
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= KEY_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    // Next-state and counter logic; a bounce during a wait state discards progress
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            KEY_IDLE: begin
                if (sample) begin
                    if (DEB_SINGLE) begin
                        state_d = KEY_PRESSED;
                        cnt_d   = '0;
                    end else begin
                        state_d = KEY_PRESS_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            KEY_PRESS_WAIT: begin
                if (!sample) begin
                    state_d = KEY_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= DEB_LAST) begin
                    state_d = KEY_PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            KEY_PRESSED: begin
                if (!sample) begin
                    if (DEB_SINGLE) begin
                        state_d = KEY_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = KEY_RELEASE_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            KEY_RELEASE_WAIT: begin
                if (sample) begin
                    state_d = KEY_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q >= DEB_LAST) begin
                    state_d = KEY_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = KEY_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode: level tracks the pressed half of the FSM, press marks acceptance
    always_comb begin
        level_d = (state_d == KEY_PRESSED) || (state_d == KEY_RELEASE_WAIT);
        press_d = (state_d == KEY_PRESSED) &&
                  ((state_q == KEY_IDLE) || (state_q == KEY_PRESS_WAIT));
    end

    assign level_o = level_q;
    assign press_o = press_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_done_q, long_done_d;
    logic              long_q, long_d;

    // Hold count advances only in PRESSED, freezes in RELEASE_WAIT, clears on release
    always_comb begin
        hold_d      = hold_q;
        long_done_d = long_done_q;
        long_d      = (state_q == KEY_PRESSED) && (hold_q == HOLD_LAST) && !long_done_q;
        if ((state_q == KEY_PRESSED) && (hold_q != HOLD_LAST)) begin
            hold_d = hold_q + HOLD_ONE;
        end
        if (long_d) begin
            long_done_d = 1'b1;
        end
        if (state_d == KEY_IDLE) begin
            hold_d      = '0;
            long_done_d = 1'b0;
        end
    end

    // Hold counter, one-shot flag and long-press pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= '0;
            long_done_q <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
            long_q      <= long_d;
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Two-key push-button debouncer with press and optional long-press pulses.
// Define KEY_DEBOUNCE_LONG_PRESS_EN to enable key*_long; otherwise they are tied 0.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic KEY0,
    input  logic KEY1,
    output logic key0_level,
    output logic key1_level,
    output logic key0_press,
    output logic key1_press,
    output logic key0_long,
    output logic key1_long
);

    // Channel for KEY0
    key_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONG_CYCLES     (LONG_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_ch0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_i   (KEY0),
        .level_o (key0_level),
        .press_o (key0_press),
        .long_o  (key0_long)
    );

    // Channel for KEY1, fully independent of KEY0
    key_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONG_CYCLES     (LONG_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_ch1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_i   (KEY1),
        .level_o (key1_level),
        .press_o (key1_press),
        .long_o  (key1_long)
    );

endmodule
